// File: rtl/vram_write_arbiter.sv
// Write-port arbiter for the 2K x 8 video RAM: two valid/ready requesters
// shared round-robin, plus a clear engine that fills every location.
module vram_write_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              write_ce,
  output logic [ADDR_W-1:0] write_ad,
  output logic [DATA_W-1:0] write_data
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  logic [0:0]        state, state_n;
  logic              last_grant, last_grant_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] fill, fill_n;
  logic              write_ce_n;
  logic [ADDR_W-1:0] write_ad_n;
  logic [DATA_W-1:0] write_data_n;
  logic              clear_busy_n, clear_done_n;
  logic              grant_a, grant_b;

  // Next-state, ready and write-port decode
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    fill_n       = fill;
    write_ce_n   = 1'b0;
    write_ad_n   = write_ad;
    write_data_n = write_data;
    clear_busy_n = clear_busy;
    clear_done_n = 1'b0;
    grant_a      = 1'b0;
    grant_b      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_n      = ST_CLEAR;
          cnt_n        = '0;
          fill_n       = clear_data;
          clear_busy_n = 1'b1;
        end else begin
          // A wins unless B is also waiting and A was served last
          grant_a = a_valid && (!b_valid || (last_grant == GRANT_B));
          grant_b = b_valid && !grant_a;
          if (grant_a) begin
            write_ce_n   = 1'b1;
            write_ad_n   = a_addr;
            write_data_n = a_data;
            last_grant_n = GRANT_A;
          end else if (grant_b) begin
            write_ce_n   = 1'b1;
            write_ad_n   = b_addr;
            write_data_n = b_data;
            last_grant_n = GRANT_B;
          end
        end
      end
      default: begin
        write_ce_n   = 1'b1;
        write_ad_n   = cnt;
        write_data_n = fill;
        cnt_n        = cnt + ADDR_W'(1);
        if (cnt == CNT_LAST) begin
          state_n      = ST_IDLE;
          cnt_n        = '0;
          clear_busy_n = 1'b0;
          clear_done_n = 1'b1;
        end
      end
    endcase
  end

  // Ready is held low while reset is asserted
  assign a_ready = grant_a && reset;
  assign b_ready = grant_b && reset;

  // State and write-port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_B;
      cnt        <= '0;
      fill       <= '0;
      write_ce   <= 1'b0;
      write_ad   <= '0;
      write_data <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      fill       <= fill_n;
      write_ce   <= write_ce_n;
      write_ad   <= write_ad_n;
      write_data <= write_data_n;
      clear_busy <= clear_busy_n;
      clear_done <= clear_done_n;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_vram_write_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0, clear_data = '0;
  logic              clear_busy, clear_done, write_ce;
  logic [ADDR_W-1:0] write_ad;
  logic [DATA_W-1:0] write_data;

  int checks = 0;
  int failures = 0;

  vram_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clear_req(clear_req), .clear_data(clear_data),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .write_ce(write_ce), .write_ad(write_ad), .write_data(write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A clear is a run of DEPTH fill writes at addresses 0,1,2,...; between
  // clears the port serves whichever requester is waiting, alternating on ties.
  logic              m_ce = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [ADDR_W-1:0] m_ad = '0;
  logic [DATA_W-1:0] m_data = '0, m_fill = '0;
  logic              m_clearing = 1'b0;
  logic              m_prefer_a = 1'b1;
  int                m_pos = 0;

  function automatic logic exp_a_ready();
    if (!reset || m_clearing || clear_req) return 1'b0;
    return a_valid && (!b_valid || m_prefer_a);
  endfunction

  function automatic logic exp_b_ready();
    if (!reset || m_clearing || clear_req) return 1'b0;
    return b_valid && !exp_a_ready();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ce <= 1'b0; m_ad <= '0; m_data <= '0; m_busy <= 1'b0; m_done <= 1'b0;
      m_clearing <= 1'b0; m_prefer_a <= 1'b1; m_pos <= 0; m_fill <= '0;
    end else if (m_clearing) begin
      m_ce   <= 1'b1;
      m_ad   <= ADDR_W'(m_pos);
      m_data <= m_fill;
      if (m_pos == DEPTH - 1) begin
        m_clearing <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_pos <= 0;
      end else begin
        m_pos <= m_pos + 1; m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (clear_req) begin
        m_clearing <= 1'b1; m_pos <= 0; m_fill <= clear_data;
        m_busy <= 1'b1; m_ce <= 1'b0;
      end else if (exp_a_ready()) begin
        m_ce <= 1'b1; m_ad <= a_addr; m_data <= a_data; m_prefer_a <= 1'b0;
      end else if (exp_b_ready()) begin
        m_ce <= 1'b1; m_ad <= b_addr; m_data <= b_data; m_prefer_a <= 1'b1;
      end else begin
        m_ce <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    chk("cmp_a_ready", 32'(a_ready), 32'(exp_a_ready()));
    chk("cmp_b_ready", 32'(b_ready), 32'(exp_b_ready()));
    chk("cmp_write_ce", 32'(write_ce), 32'(m_ce));
    chk("cmp_clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("cmp_clear_done", 32'(clear_done), 32'(m_done));
    if (m_ce) begin
      chk("cmp_write_ad", 32'(write_ad), 32'(m_ad));
      chk("cmp_write_data", 32'(write_data), 32'(m_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic single_write(input logic is_a, input logic [ADDR_W-1:0] ad,
                              input logic [DATA_W-1:0] dt);
    tick();
    if (is_a) begin a_valid = 1'b1; a_addr = ad; a_data = dt; end
    else      begin b_valid = 1'b1; b_addr = ad; b_data = dt; end
    @(negedge clk);
    chk(is_a ? "single_ready_a" : "single_ready_b", 32'(is_a ? a_ready : b_ready), 32'd1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("single_ce", 32'(write_ce), 32'd1);
    chk("single_ad", 32'(write_ad), 32'(ad));
    chk("single_data", 32'(write_data), 32'(dt));
    @(negedge clk);
    chk("single_ce_after", 32'(write_ce), 32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] cont_ad [4];
    int ce_cnt, done_cnt, hit;
    logic a_fire, b_fire;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      a_valid = 1'($urandom); b_valid = 1'($urandom); clear_req = 1'($urandom);
      a_addr = ADDR_W'($urandom); b_addr = ADDR_W'($urandom);
      a_data = DATA_W'($urandom); b_data = DATA_W'($urandom);
      @(negedge clk);
      chk("rst_ce", 32'(write_ce), 32'd0);
      chk("rst_ad", 32'(write_ad), 32'd0);
      chk("rst_data", 32'(write_data), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    reset = 1'b1;

    // Single A write, then single B write so A leads the contention run
    single_write(1'b1, 11'h123, 8'h5A);
    single_write(1'b0, 11'h456, 8'hC3);

    // Contention: A, B, A, B
    tick();
    a_valid = 1'b1; a_addr = 11'h010; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 11'h020; b_data = 8'h22;
    cont_ad[0] = 11'h010; cont_ad[1] = 11'h020; cont_ad[2] = 11'h010; cont_ad[3] = 11'h020;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_grant_a", 32'(a_ready), 32'((k % 2) == 0));
      chk("cont_grant_b", 32'(b_ready), 32'((k % 2) == 1));
      if (k > 0) chk("cont_ad", 32'(write_ad), 32'(cont_ad[k-1]));
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("cont_ce_last", 32'(write_ce), 32'd1);
    chk("cont_ad_last", 32'(write_ad), 32'(cont_ad[3]));

    // Full clear with simultaneous A request
    tick();
    clear_req = 1'b1; clear_data = 8'h20;
    a_valid = 1'b1; a_addr = 11'h055; a_data = 8'h66;
    @(negedge clk);
    chk("simul_a_ready", 32'(a_ready), 32'd0);
    tick();
    clear_req = 1'b0;
    ce_cnt = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      @(negedge clk);
      if (write_ce) begin
        if (write_ad !== ADDR_W'(ce_cnt)) chk("clr_ad", 32'(write_ad), 32'(ce_cnt));
        if (write_data !== 8'h20) chk("clr_data", 32'(write_data), 32'h20);
        ce_cnt++;
      end
      if (clear_busy && a_ready) chk("clr_a_ready_busy", 32'(a_ready), 32'd0);
      if (clear_done) begin
        done_cnt++;
        chk("clr_done_ad", 32'(write_ad), 32'h7FF);
        chk("clr_done_a_ready", 32'(a_ready), 32'd1);
        break;
      end
    end
    chk("clr_ce_count", 32'(ce_cnt), 32'(DEPTH));
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("post_clr_a_ce", 32'(write_ce), 32'd1);
    chk("post_clr_a_ad", 32'(write_ad), 32'h055);
    chk("post_clr_a_data", 32'(write_data), 32'h66);
    chk("post_clr_done", 32'(clear_done), 32'd0);

    // Reset mid-clear at address 0x100
    tick();
    clear_req = 1'b1; clear_data = 8'hA5;
    tick();
    clear_req = 1'b0;
    hit = 0;
    for (int i = 0; i < 400 && hit == 0; i++) begin
      @(negedge clk);
      if (write_ce && write_ad == 11'h100) hit = 1;
    end
    chk("midclr_reached", 32'(hit), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midclr_ce", 32'(write_ce), 32'd0);
    chk("midclr_ad", 32'(write_ad), 32'd0);
    chk("midclr_data", 32'(write_data), 32'd0);
    chk("midclr_busy", 32'(clear_busy), 32'd0);
    chk("midclr_done", 32'(clear_done), 32'd0);
    tick(); tick();
    reset = 1'b1;
    ce_cnt = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (write_ce) ce_cnt++;
      if (clear_done) done_cnt++;
    end
    chk("midclr_no_writes", 32'(ce_cnt), 32'd0);
    chk("midclr_no_done", 32'(done_cnt), 32'd0);

    // Randomized traffic, requesters obey valid/ready hold rules
    tick();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      tick();
      if (!a_valid || a_fire) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr = ADDR_W'($urandom); a_data = DATA_W'($urandom);
      end
      if (!b_valid || b_fire) begin
        b_valid = ($urandom_range(0, 99) < 60);
        b_addr = ADDR_W'($urandom); b_data = DATA_W'($urandom);
      end
      clear_req = ($urandom_range(0, 999) < 2);
      clear_data = DATA_W'($urandom);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
